// File: rtl/laser_job_sched.sv
// Job scheduler for the two-circle laser-coverage engine: round-robin grant, point buffering,
// gap-free launch into the engine, DONE/timeout wait and a valid/ready result return.
module laser_job_sched #(
  parameter int NPTS    = 40,
  parameter int TIMEOUT = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  output logic [1:0] GNT,
  input  logic [3:0] PX,
  input  logic [3:0] PY,
  input  logic       PVALID,
  output logic       PREADY,
  output logic       RVALID,
  input  logic       RREADY,
  output logic [3:0] RC1X,
  output logic [3:0] RC1Y,
  output logic [3:0] RC2X,
  output logic [3:0] RC2Y,
  output logic       RERR,
  output logic       RID,
  output logic       BUSY,
  output logic       ENG_RST,
  output logic [3:0] ENG_X,
  output logic [3:0] ENG_Y,
  input  logic [3:0] ENG_C1X,
  input  logic [3:0] ENG_C1Y,
  input  logic [3:0] ENG_C2X,
  input  logic [3:0] ENG_C2Y,
  input  logic       ENG_DONE,
  output logic [2:0] STATE_DBG
);

  localparam int CW = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int TW = 16;

  // Handshakes: a point moves on PVALID&PREADY, a result on RVALID&RREADY; a side that has
  // raised valid holds its data stable until the transfer edge.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [7:0]    buf_mem [NPTS];
  logic [CW-1:0] wcnt, wcnt_n, rcnt, rcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          last_id, last_id_n;
  logic [1:0]    gnt_n;
  logic          pready_n, rvalid_n, rerr_n, rid_n, busy_n, eng_rst_n;
  logic [3:0]    rc1x_n, rc1y_n, rc2x_n, rc2y_n, eng_x_n, eng_y_n;
  logic          xfer;
  logic [7:0]    first_pt;

  assign xfer      = PVALID & PREADY;
  assign STATE_DBG = state;
  // With a one-point job the only point is still being written when the launch starts.
  assign first_pt  = (NPTS == 1) ? {PY, PX} : buf_mem[0];

  always_ff @(posedge CLK) begin
    if (state == S_LOAD && xfer) buf_mem[wcnt] <= {PY, PX};
  end

  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    rcnt_n    = rcnt;
    tcnt_n    = tcnt;
    last_id_n = last_id;
    gnt_n     = GNT;
    pready_n  = PREADY;
    rvalid_n  = RVALID;
    rerr_n    = RERR;
    rid_n     = RID;
    eng_rst_n = ENG_RST;
    eng_x_n   = ENG_X;
    eng_y_n   = ENG_Y;
    rc1x_n    = RC1X;
    rc1y_n    = RC1Y;
    rc2x_n    = RC2X;
    rc2y_n    = RC2Y;
    case (state)
      S_IDLE: begin
        if (REQ != 2'b00) begin
          rid_n    = (REQ == 2'b11) ? ~last_id : REQ[1];
          gnt_n    = rid_n ? 2'b10 : 2'b01;
          pready_n = 1'b1;
          state_n  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!REQ[RID]) begin
          gnt_n    = 2'b00;
          wcnt_n   = '0;
          pready_n = 1'b0;
          state_n  = S_IDLE;
        end else if (xfer) begin
          if (wcnt == CW'(NPTS - 1)) begin
            wcnt_n             = '0;
            rcnt_n             = '0;
            pready_n           = 1'b0;
            eng_rst_n          = 1'b0;
            {eng_y_n, eng_x_n} = first_pt;
            state_n            = S_LAUNCH;
          end else begin
            wcnt_n = wcnt + 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        // Each cycle presents buf[rcnt]; the next point is fetched one cycle ahead.
        if (rcnt == CW'(NPTS - 1)) begin
          rcnt_n  = '0;
          eng_x_n = '0;
          eng_y_n = '0;
          state_n = S_WAIT;
        end else begin
          rcnt_n             = rcnt + 1'b1;
          {eng_y_n, eng_x_n} = buf_mem[rcnt_n];
        end
      end
      S_WAIT: begin
        tcnt_n = tcnt + 1'b1;
        if (ENG_DONE) begin
          rc1x_n    = ENG_C1X;
          rc1y_n    = ENG_C1Y;
          rc2x_n    = ENG_C2X;
          rc2y_n    = ENG_C2Y;
          rerr_n    = 1'b0;
          rvalid_n  = 1'b1;
          eng_rst_n = 1'b1;
          state_n   = S_RESP;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          rc1x_n    = '0;
          rc1y_n    = '0;
          rc2x_n    = '0;
          rc2y_n    = '0;
          rerr_n    = 1'b1;
          rvalid_n  = 1'b1;
          eng_rst_n = 1'b1;
          state_n   = S_RESP;
        end
      end
      S_RESP: begin
        if (RREADY) begin
          last_id_n = RID;
          gnt_n     = 2'b00;
          rvalid_n  = 1'b0;
          tcnt_n    = '0;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      rcnt    <= '0;
      tcnt    <= '0;
      last_id <= 1'b1;
      GNT     <= 2'b00;
      PREADY  <= 1'b0;
      RVALID  <= 1'b0;
      RERR    <= 1'b0;
      RID     <= 1'b0;
      BUSY    <= 1'b0;
      ENG_RST <= 1'b1;
      ENG_X   <= '0;
      ENG_Y   <= '0;
      RC1X    <= '0;
      RC1Y    <= '0;
      RC2X    <= '0;
      RC2Y    <= '0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      rcnt    <= rcnt_n;
      tcnt    <= tcnt_n;
      last_id <= last_id_n;
      GNT     <= gnt_n;
      PREADY  <= pready_n;
      RVALID  <= rvalid_n;
      RERR    <= rerr_n;
      RID     <= rid_n;
      BUSY    <= busy_n;
      ENG_RST <= eng_rst_n;
      ENG_X   <= eng_x_n;
      ENG_Y   <= eng_y_n;
      RC1X    <= rc1x_n;
      RC1Y    <= rc1y_n;
      RC2X    <= rc2x_n;
      RC2Y    <= rc2y_n;
    end
  end

endmodule

// File: doc/laser_job_sched.md
Name: laser_job_sched

Overview:
Job scheduler and sequencer for the two-circle laser-coverage engine. Two point-set requesters compete for the single engine. The block grants one requester round-robin and buffers that requester's NPTS points. It then resets the engine and streams the points gap-free in the exact cycle window the engine samples. It waits for the engine's DONE pulse, with a timeout, and returns the two circle centres to the granted requester over a valid/ready handshake.

Parameters:
NPTS, 40, points per job; also the buffer depth and the gap-free launch length.
TIMEOUT, 4096, maximum WAIT cycles before the job is aborted with an error; must be ≤ 65535.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, synchronous, active-high.
REQ  in  2  per-requester job request; level, held high until the response is accepted.
GNT  out  2  one-hot grant; held from grant until response accepted or job aborted.
PX  in  4  point X from the granted requester.
PY  in  4  point Y from the granted requester.
PVALID  in  1  point valid.
PREADY  out  1  point accept; a point transfers when PVALID&PREADY.
RVALID  out  1  result valid.
RREADY  in  1  result accept.
RC1X, RC1Y, RC2X, RC2Y  out  4 each  result circle centres.
RERR  out  1  1 = engine timed out; coordinates are then 0.
RID  out  1  index of the granted requester.
BUSY  out  1  high in every state except IDLE.
ENG_RST  out  1  engine synchronous reset.
ENG_X, ENG_Y  out  4 each  point to the engine.
ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y  in  4 each  engine result.
ENG_DONE  in  1  engine single-cycle done pulse; valid in the same cycle as the ENG_C* values.

Behaviour:
- Reset values (all registered): state=IDLE, GNT=0, PREADY=0, RVALID=0, RC*=0, RERR=0, RID=0, BUSY=0, ENG_RST=1, ENG_X=ENG_Y=0, last_id=1 so requester 0 wins first. Counters wcnt, rcnt and tcnt all reset to 0.
- Reset asserted mid-job forces the reset values on the next edge. No response is issued and the buffer contents are don't-care.
- IDLE: ENG_RST=1.
  - If REQ!=0, grant next cycle: if both requesters request, grant the one ≠ last_id; otherwise grant the single requester.
  - Set GNT and RID, then go to LOAD.
- LOAD: PREADY=1.
  - Each transfer writes buf[wcnt]={PY,PX} and increments wcnt.
  - When the transfer with wcnt=NPTS-1 occurs, clear wcnt, drop PREADY and go to LAUNCH.
  - If REQ[RID] falls during LOAD, abort: GNT=0, wcnt=0, go to IDLE. last_id is unchanged and no response is issued.
- LAUNCH: lasts exactly NPTS cycles, k=0..NPTS-1.
  - ENG_RST=0 in all of them; ENG_X/ENG_Y=buf[k] in cycle k. Cycle 0 is the first cycle ENG_RST is low.
  - No bubbles are allowed. REQ is ignored from here until RESP completes.
  - After cycle NPTS-1 go to WAIT with ENG_X/Y=0.
- WAIT: ENG_RST=0; tcnt increments each cycle.
  - ENG_DONE=1: capture ENG_C* into RC*, set RERR=0, go to RESP.
  - tcnt=TIMEOUT-1 with no DONE: RC*=0, RERR=1, go to RESP.
  - If ENG_DONE and the timeout occur in the same cycle, DONE wins.
  - ENG_DONE in any other state is ignored.
- RESP: ENG_RST=1; RVALID=1.
  - RC*, RERR and RID stay stable until RREADY.
  - On the RVALID&RREADY cycle: last_id<=RID, GNT<=0, RVALID<=0, tcnt<=0, go to IDLE.
  - A new grant is issued no earlier than the cycle after returning to IDLE.
- Minimum job latency, from grant to RVALID: NPTS (load, no gaps) + NPTS (launch) + engine time + 1.

Test Plan:
1. REQ=01; 40 points fed with no gaps, 20 at (3,3) and 20 at (12,12). Expect GNT=01. ENG_RST is low for 40 launch cycles carrying the points in order. Drive ENG_DONE with C1=(3,3), C2=(12,12). Expect RVALID with RC1X=3, RC1Y=3, RC2X=12, RC2Y=12, RERR=0, RID=0.
2. REQ=11 from reset, both requesters holding jobs. Expect requester 0 served first, then requester 1 (RID=1). Requester 0 re-requests immediately and is granted third, confirming round-robin.
3. PVALID toggling every other cycle during LOAD. Expect LAUNCH still 40 consecutive cycles with ENG_X/Y matching input order, and no extra or missing samples.
4. Engine never pulses DONE, with TIMEOUT=16 in the bench instance. Expect RVALID exactly 16 cycles after WAIT entry, RERR=1, all RC*=0.
5. REQ[0] dropped after 10 points. Expect GNT=00 next cycle, BUSY=0, no RVALID, and the next job's first point written at buf[0].
6. RREADY held low 5 cycles in RESP, and RST asserted during LAUNCH in a second run. Expect RC* stable until acceptance. On RST, expect all outputs at reset values one edge later, with ENG_RST=1.
